oam_dma_controller: RTL
=======================

// Module: oam_dma_controller
// PURPOSE
//  OAM DMA engine ($4014). On a CPU write of a page number, halts the CPU and copies
//  TRANSFER_LENGTH bytes from CPU bus {page,00}..{page,FF} into OAM through the $2004 data
//  path, one byte per get/put cycle pair. It feeds the sprite handler's primary OAM write
//  port (cpuComm_EN/cpuData_IN); OAMADDR is held and auto-incremented by the $2004 register logic.
// PARAMETERS
//  TRANSFER_LENGTH  256  bytes per DMA, legal range 1..256; index wraps modulo 256
//  HALT_CYCLES      1    CPU cycles in HALT before the first get/put (range 1..3)
// PORTS
//  clock           in   1   system clock (single clock domain)
//  reset           in   1   synchronous, active-high; sampled every clock edge, ignores cpuCycle_EN
//  cpuCycle_EN     in   1   one-clock strobe per CPU cycle; all state advances only when high
//  dmaStart        in   1   decoded CPU write to $4014, valid on a cpuCycle_EN clock
//  dmaPage_IN      in   8   page number written to $4014
//  busData_IN      in   8   CPU bus read data returned for busAddress_OUT
//  cpuHalt         out  1   CPU RDY-low request; high from HALT through last WRITE
//  busAddress_OUT  out  16  {page, index} during READ; 0 otherwise
//  busRead         out  1   high during READ cycle
//  oamWrite_EN     out  1   high for exactly the WRITE CPU cycle; acts as a $2004 write
//  oamData_OUT     out  8   latched byte presented during WRITE
//  dmaActive       out  1   high whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, index=0, page=0, parity=0; all outputs 0. Reset mid-transfer aborts
//    immediately, no further OAM writes, cpuHalt drops on the next clock.
//  - parity: free-running toggle on every cpuCycle_EN from reset; 0=get cycle, 1=put cycle.
//  - Clocks with cpuCycle_EN=0: all registers and outputs hold.
//  - States (transitions on cpuCycle_EN clocks only):
//    IDLE : dmaStart=1 -> latch page, index=0, HALT (halt counter=HALT_CYCLES-1).
//    HALT : cpuHalt=1; counter counts down; at 0 -> ALIGN if the next cycle is a put
//           (current parity=0), else READ.
//    ALIGN: one dummy cycle, no bus activity -> READ.
//    READ : busRead=1, busAddress_OUT={page,index}; busData_IN latched into oamData_OUT at end
//           of cycle -> WRITE.
//    WRITE: oamWrite_EN=1 with oamData_OUT; if index==TRANSFER_LENGTH-1 -> IDLE, else
//           index+1 -> READ.
//  - Outputs are registered: they reflect the state entered on the previous cpuCycle_EN edge.
//  - Total halt with defaults: 1 + 512 = 513 CPU cycles (aligned) or 514 (ALIGN inserted).
//  - READ always lands on a get cycle, WRITE on a put cycle.
//  - dmaStart while dmaActive: ignored (page not relatched).
//  - dmaStart together with reset: reset wins.
//  - index is 8 bits: TRANSFER_LENGTH=256 ends at FF without overflow, page never increments.
//  - The block does not touch OAMADDR; the OAM byte sequence starts at the current OAMADDR and
//    wraps modulo 256.
// CONFIGURATION
//  OAM_DMA_ALIGN_EN defined  : ALIGN state is present; parity-accurate 513/514 cycle timing.
//  OAM_DMA_ALIGN_EN undefined: ALIGN removed; HALT -> READ unconditionally; always
//                              HALT_CYCLES+512 cycles; READ/WRITE parity is not guaranteed.
// TESTING
//  1. Page 0x02, RAM $0200+i = i^0x5A, start on a parity-1 cycle -> 256 oamWrite_EN pulses,
//     data i^0x5A in order, cpuHalt high for 513 cycles.
//  2. Same as 1, start on a parity-0 cycle -> one ALIGN cycle, cpuHalt high for 514 cycles
//     (macro on); 513 cycles with the macro off.
//  3. Reset asserted at byte 100 (during READ) -> oamWrite_EN never pulses again, all outputs 0
//     the next clock, state IDLE.
//  4. Second dmaStart with page 0x07 during a transfer from page 0x03 -> busAddress_OUT stays
//     0x03xx; exactly 256 writes.
//  5. cpuCycle_EN high only every 3rd clock -> identical write sequence; outputs stable between
//     enables.
//  6. TRANSFER_LENGTH=4, page 0xFF -> addresses FF00..FF03, 4 writes, dmaActive drops after the
//     4th WRITE.

Source files
------------

// File: rtl/oam_dma_controller.sv
//==============================================================================
// Module      : oam_dma_controller
// Description : $4014 OAM DMA engine; halts the CPU and copies a page into OAM
//               through the $2004 write path. OAM_DMA_ALIGN_EN adds the ALIGN state.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module oam_dma_controller #(
    parameter int TRANSFER_LENGTH = 256,
    parameter int HALT_CYCLES     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpuCycle_EN,
    input  logic        dmaStart,
    input  logic [7:0]  dmaPage_IN,
    input  logic [7:0]  busData_IN,
    output logic        cpuHalt,
    output logic [15:0] busAddress_OUT,
    output logic        busRead,
    output logic        oamWrite_EN,
    output logic [7:0]  oamData_OUT,
    output logic        dmaActive
);

    localparam logic [2:0] c_STATE_IDLE  = 3'd0;
    localparam logic [2:0] c_STATE_HALT  = 3'd1;
`ifdef OAM_DMA_ALIGN_EN
    localparam logic [2:0] c_STATE_ALIGN = 3'd2;
`endif
    localparam logic [2:0] c_STATE_READ  = 3'd3;
    localparam logic [2:0] c_STATE_WRITE = 3'd4;

    localparam logic [7:0] c_LAST_INDEX = 8'(TRANSFER_LENGTH - 1);
    localparam logic [1:0] c_HALT_INIT  = 2'(HALT_CYCLES - 1);

    logic [2:0] r_state;
    logic [7:0] r_index;
    logic [7:0] r_page;
    logic [1:0] r_haltCount;
`ifdef OAM_DMA_ALIGN_EN
    logic       r_parity;
`endif

    logic [2:0] w_nextState;
    logic [7:0] w_nextIndex;
    logic [7:0] w_nextPage;
    logic [1:0] w_nextHaltCount;

    always_comb begin
        w_nextState     = r_state;
        w_nextIndex     = r_index;
        w_nextPage      = r_page;
        w_nextHaltCount = r_haltCount;
        case (r_state)
            c_STATE_IDLE: begin
                if (dmaStart) begin
                    w_nextState     = c_STATE_HALT;
                    w_nextPage      = dmaPage_IN;
                    w_nextIndex     = 8'd0;
                    w_nextHaltCount = c_HALT_INIT;
                end
            end
            c_STATE_HALT: begin
                if (r_haltCount == 2'd0) begin
`ifdef OAM_DMA_ALIGN_EN
                    // parity 0 now means the next cycle is a put; burn it so READ lands on a get
                    w_nextState = r_parity ? c_STATE_READ : c_STATE_ALIGN;
`else
                    w_nextState = c_STATE_READ;
`endif
                end else begin
                    w_nextHaltCount = r_haltCount - 2'd1;
                end
            end
`ifdef OAM_DMA_ALIGN_EN
            c_STATE_ALIGN: w_nextState = c_STATE_READ;
`endif
            c_STATE_READ:  w_nextState = c_STATE_WRITE;
            c_STATE_WRITE: begin
                if (r_index == c_LAST_INDEX) begin
                    w_nextState = c_STATE_IDLE;
                    w_nextIndex = 8'd0;
                end else begin
                    w_nextState = c_STATE_READ;
                    w_nextIndex = r_index + 8'd1;
                end
            end
            default: w_nextState = c_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= c_STATE_IDLE;
            r_index        <= 8'd0;
            r_page         <= 8'd0;
            r_haltCount    <= 2'd0;
`ifdef OAM_DMA_ALIGN_EN
            r_parity       <= 1'b0;
`endif
            cpuHalt        <= 1'b0;
            busAddress_OUT <= 16'h0000;
            busRead        <= 1'b0;
            oamWrite_EN    <= 1'b0;
            oamData_OUT    <= 8'h00;
            dmaActive      <= 1'b0;
        end else if (cpuCycle_EN) begin
            r_state        <= w_nextState;
            r_index        <= w_nextIndex;
            r_page         <= w_nextPage;
            r_haltCount    <= w_nextHaltCount;
`ifdef OAM_DMA_ALIGN_EN
            r_parity       <= ~r_parity;
`endif
            // Outputs are decoded from the state being entered so they are registered
            cpuHalt        <= (w_nextState != c_STATE_IDLE);
            dmaActive      <= (w_nextState != c_STATE_IDLE);
            busRead        <= (w_nextState == c_STATE_READ);
            oamWrite_EN    <= (w_nextState == c_STATE_WRITE);
            busAddress_OUT <= (w_nextState == c_STATE_READ) ? {w_nextPage, w_nextIndex} : 16'h0000;
            if (r_state == c_STATE_READ) begin
                oamData_OUT <= busData_IN;
            end
        end
    end

endmodule

`default_nettype wire
